ws2811_frame_driver: RTL

Parametrised WS2811 strip driver with an internal frame buffer of up to MAX_LEDS 24-bit colours, global brightness scaling and single-shot or continuous refresh. Host logic writes colours through a simple write port and triggers a frame. The block then streams every LED word with cycle-exact WS2811 bit timing, followed by the latch/reset gap. It replaces the fixed-count array controller wherever strip length, timing or refresh mode must vary.

---
 rtl/ws2811_pkg.sv | 41 ++++
 rtl/ws2811_bit_encoder.sv | 55 +++++
 rtl/ws2811_frame_driver.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/ws2811_pkg.sv
// Shared types, default WS2811 timing and the per-channel brightness scaler
// used by the frame driver.
package ws2811_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_LATCH
    } state_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } color_t;

    localparam int DEF_MAX_LEDS = 64;
    localparam int DEF_BIT_CYC  = 125;
    localparam int DEF_T0H_CYC  = 25;
    localparam int DEF_T1H_CYC  = 60;
    localparam int DEF_RST_CYC  = 2500;

    // (c * (b + 1)) >> 8 per channel: b=255 is unity, b=0 is black.
    function automatic color_t scale(input color_t c, input logic [7:0] b);
        logic [15:0] k;
        logic [15:0] pr;
        logic [15:0] pg;
        logic [15:0] pb;
        color_t      o;
        k    = {8'd0, b} + 16'd1;
        pr   = {8'd0, c.r} * k;
        pg   = {8'd0, c.g} * k;
        pb   = {8'd0, c.b} * k;
        o.r  = 8'(pr >> 8);
        o.g  = 8'(pg >> 8);
        o.b  = 8'(pb >> 8);
        return o;
    endfunction

endpackage

// File: rtl/ws2811_bit_encoder.sv
// One WS2811 bit cell: high for T0H/T1H cycles, low for the rest of BIT_CYC.
// A bit_start during bit_last chains the next bit with no idle cycle.
module ws2811_bit_encoder
    import ws2811_pkg::*;
#(
    parameter int BIT_CYC = DEF_BIT_CYC,
    parameter int T0H_CYC = DEF_T0H_CYC,
    parameter int T1H_CYC = DEF_T1H_CYC
) (
    input  logic clock,
    input  logic reset,
    input  logic bit_val,
    input  logic bit_start,
    output logic serial_bit,
    output logic bit_last
);

    localparam int CW = $clog2(BIT_CYC);
    localparam logic [CW-1:0] LAST_CNT = CW'(BIT_CYC - 1);
    localparam logic [CW-1:0] T0_CNT   = CW'(T0H_CYC);
    localparam logic [CW-1:0] T1_CNT   = CW'(T1H_CYC);

    logic [CW-1:0] r_cnt;
    logic          r_active;
    logic          r_val;
    logic          r_serial;
    logic [CW-1:0] w_high;

    assign w_high     = r_val ? T1_CNT : T0_CNT;
    assign bit_last   = r_active && (r_cnt == LAST_CNT);
    assign serial_bit = r_serial;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_active <= 1'b0;
            r_serial <= 1'b0;
            r_cnt    <= '0;
            r_val    <= 1'b0;
        end else if (bit_start) begin
            r_active <= 1'b1;
            r_serial <= 1'b1;
            r_cnt    <= '0;
            r_val    <= bit_val;
        end else if (r_active) begin
            if (r_cnt == LAST_CNT) begin
                r_active <= 1'b0;
                r_serial <= 1'b0;
            end else begin
                r_cnt    <= r_cnt + 1'b1;
                r_serial <= ((r_cnt + 1'b1) < w_high);
            end
        end
    end

endmodule

// File: rtl/ws2811_frame_driver.sv
// WS2811 strip driver: frame buffer, brightness scaling, gapless bit stream
// and latch gap, in single-shot or continuous refresh.
module ws2811_frame_driver
    import ws2811_pkg::*;
#(
    parameter int MAX_LEDS = DEF_MAX_LEDS,
    parameter int BIT_CYC  = DEF_BIT_CYC,
    parameter int T0H_CYC  = DEF_T0H_CYC,
    parameter int T1H_CYC  = DEF_T1H_CYC,
    parameter int RST_CYC  = DEF_RST_CYC,
    localparam int AW      = $clog2(MAX_LEDS)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [23:0]   wr_data,
    input  logic [AW:0]   led_count,
    input  logic [7:0]    brightness,
    input  logic          start,
    input  logic          continuous,
    output logic          busy,
    output logic          frame_done,
    output logic          serial,
    output logic          db_serial
);

    localparam int LW = $clog2(RST_CYC + 1);
    localparam logic [AW:0]   MAX_CNT   = (AW+1)'(MAX_LEDS);
    localparam logic [LW-1:0] LAT_START = LW'(RST_CYC - 1);
    localparam logic          LAT_ONE   = (RST_CYC == 1);

    state_t        r_state;
    color_t        r_buf [MAX_LEDS];
    color_t        r_rd_data;
    color_t        r_word;
    logic [4:0]    r_bit;
    logic [AW:0]   r_led;
    logic [AW:0]   r_count;
    logic [7:0]    r_bright;
    logic [LW-1:0] r_lat;
    logic          r_busy;
    logic          r_done;

    color_t        w_scaled;
    logic [AW:0]   w_count_in;
    logic          w_last_led;
    logic          w_rd_en;
    logic [AW-1:0] w_rd_addr;
    logic          w_bit_start;
    logic          w_bit_val;
    logic          w_bit_last;
    logic          w_serial;

    assign w_scaled   = scale(r_rd_data, r_bright);
    assign w_count_in = (led_count > MAX_CNT) ? MAX_CNT : led_count;
    assign w_last_led = (r_led == r_count - 1'b1);

    // Reads are registered; the next word is fetched as bit 23 begins.
    always_comb begin
        w_rd_en   = 1'b0;
        w_rd_addr = '0;
        case (r_state)
            S_IDLE:  w_rd_en = start;
            S_LATCH: w_rd_en = (r_lat == '0) && continuous;
            S_SEND: begin
                w_rd_en   = w_bit_last && (r_bit == 5'd22);
                w_rd_addr = AW'(r_led + 1'b1);
            end
            default: w_rd_en = 1'b0;
        endcase
    end

    always_comb begin
        w_bit_start = 1'b0;
        w_bit_val   = 1'b0;
        case (r_state)
            S_LOAD: begin
                w_bit_start = (r_count != '0);
                w_bit_val   = w_scaled[23];
            end
            S_SEND: begin
                if (w_bit_last) begin
                    if (r_bit == 5'd23) begin
                        w_bit_start = !w_last_led;
                        w_bit_val   = w_scaled[23];
                    end else begin
                        w_bit_start = 1'b1;
                        w_bit_val   = r_word[22];
                    end
                end
            end
            default: w_bit_start = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < MAX_LEDS; i++) r_buf[i] <= '0;
        end else begin
            if (wr_en) r_buf[wr_addr] <= wr_data;
            if (w_rd_en) r_rd_data <= r_buf[w_rd_addr];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_bit   <= '0;
            r_led   <= '0;
            r_lat   <= '0;
            r_count <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state  <= S_LOAD;
                        r_busy   <= 1'b1;
                        r_count  <= w_count_in;
                        r_bright <= brightness;
                    end
                end
                S_LOAD: begin
                    r_word <= w_scaled;
                    r_bit  <= '0;
                    r_led  <= '0;
                    if (r_count == '0) begin
                        r_state <= S_LATCH;
                        r_lat   <= LAT_START;
                        r_done  <= LAT_ONE;
                    end else begin
                        r_state <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (w_bit_last) begin
                        if (r_bit == 5'd23) begin
                            if (w_last_led) begin
                                r_state <= S_LATCH;
                                r_lat   <= LAT_START;
                                r_done  <= LAT_ONE;
                            end else begin
                                r_led  <= r_led + 1'b1;
                                r_bit  <= '0;
                                r_word <= w_scaled;
                            end
                        end else begin
                            r_bit  <= r_bit + 1'b1;
                            r_word <= color_t'({r_word[22:0], 1'b0});
                        end
                    end
                end
                S_LATCH: begin
                    if (r_lat == '0) begin
                        if (continuous) begin
                            r_state  <= S_LOAD;
                            r_count  <= w_count_in;
                            r_bright <= brightness;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_lat <= r_lat - 1'b1;
                        if (r_lat == LW'(1)) r_done <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    ws2811_bit_encoder #(
        .BIT_CYC (BIT_CYC),
        .T0H_CYC (T0H_CYC),
        .T1H_CYC (T1H_CYC)
    ) u_enc (
        .clock      (clock),
        .reset      (reset),
        .bit_val    (w_bit_val),
        .bit_start  (w_bit_start),
        .serial_bit (w_serial),
        .bit_last   (w_bit_last)
    );

    assign serial     = w_serial;
    assign db_serial  = w_serial;
    assign busy       = r_busy;
    assign frame_done = r_done;

endmodule
